arbiter_rr_buffered: RTL and testbench

//  N-input round-robin arbiter with a registered output stage. It merges N valid/ready

---
 rtl/arbiter_pkg.sv | 15 +
 rtl/rr_priority_select.sv | 53 +++++
 rtl/arbiter_rr_buffered.sv | 131 +++++++++++++
 tb/tb_arbiter_rr_buffered.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared helpers for the buffered round-robin arbiter.
// Holds the index-width calculation and the modulo-n pointer increment.
package arbiter_pkg;

   // Width of a channel index. Never collapses to zero bits, even for one channel.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Next channel after idx, wrapping n-1 back to 0.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority selector.
// Channel lowest_prio+1 has the highest priority and lowest_prio has the lowest.
// The request vector is doubled: the lower copy is masked to the channels above the
// pointer, and the upper copy is the full request vector. The first set bit of the
// doubled vector, taken mod N, is the winner.
module rr_priority_select
   import arbiter_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] lowest_prio,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   logic [N-1:0]   upper_mask;
   logic [2*N-1:0] dbl_req;
   logic           found;
   int             sel;

   // Mask of channels strictly above the pointer; these are searched first.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      upper_mask = '0;
      for (int i = 0; i < N; i++) begin
         upper_mask[i] = (i > int'(lowest_prio));
      end
   end

   assign dbl_req = {req, req & upper_mask};

   // First set bit of the doubled vector, folded back to a channel index.
   always_comb begin
      found = 1'b0;
      sel   = 0;
      for (int i = 0; i < 2 * N; i++) begin
         if (!found && dbl_req[i]) begin
            found = 1'b1;
            sel   = i;
         end
      end
      grant_idx = IDX_W'((sel >= N) ? sel - N : sel);
      grant     = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = found && (grant_idx == IDX_W'(i));
      end
      any = found;
   end

endmodule

// File: rtl/arbiter_rr_buffered.sv
// N-input round-robin arbiter with a registered output stage.
// Merges N valid/ready streams into one at one beat per cycle. The channel granted
// last becomes lowest priority, so no channel starves. The output register holds
// payload, source index and valid, and stalls cleanly under out_ready backpressure.
// Optional feature: define ARB_RR_BURST_LOCK_EN to add in_last/out_last and lock the
// grant to a channel until it delivers a beat with in_last set.
module arbiter_rr_buffered
   import arbiter_pkg::*;
#(
   parameter  int DWIDTH           = 16,
   parameter  int N                = 4,
   parameter  int INIT_LOWEST_PRIO = N - 1,
   localparam int IDX_W            = idx_width(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid [N-1:0],
   input  logic [DWIDTH-1:0] in_data  [N-1:0],
   output logic              in_ready [N-1:0],
   input  logic              shift,
   output logic              out_valid,
   output logic [DWIDTH-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   input  logic              out_ready
`ifdef ARB_RR_BURST_LOCK_EN
   ,
   input  logic              in_last  [N-1:0],
   output logic              out_last
`endif
);

   logic [IDX_W-1:0] lowest_prio;
   logic [N-1:0]     eligible;
   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] grant_idx;
   logic             any;
   logic             load_en;
   logic             accept;
   logic             lock_hold;

   // The output register can take a new beat when it is empty or being drained.
   assign load_en = !out_valid || out_ready;
   assign accept  = load_en && any;

`ifdef ARB_RR_BURST_LOCK_EN
   logic             locked;
   logic [IDX_W-1:0] lock_idx;

   // While a burst is open only its owner may request; others are masked out.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < N; i++) begin
         eligible[i] = !locked || (lock_idx == IDX_W'(i));
      end
   end

   assign lock_hold = locked;

   // Burst tracking: a non-last beat opens or continues a lock, a last beat closes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked   <= 1'b0;
         lock_idx <= '0;
         out_last <= 1'b0;
      end else if (accept) begin
         locked   <= !in_last[grant_idx];
         lock_idx <= grant_idx;
         out_last <= in_last[grant_idx];
      end
   end
`else
   assign eligible  = '1;
   assign lock_hold = 1'b0;
`endif

   // Request vector seen by the selector: valid channels that are currently eligible.
   always_comb begin
      req = '0;
      for (int i = 0; i < N; i++) begin
         req[i] = in_valid[i] && eligible[i];
      end
   end

   rr_priority_select #(
      .N (N)
   ) u_select (
      .req         (req),
      .lowest_prio (lowest_prio),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .any         (any)
   );

   // Per-channel ready: only the winner, only when the output can load, never in reset.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         in_ready[i] = load_en && grant[i] && !rst;
      end
   end

   // Output register: load the winner, go empty when nothing requests, hold on stall.
   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else if (load_en) begin
         out_valid <= any;
         if (any) begin
            out_data  <= in_data[grant_idx];
            out_index <= grant_idx;
         end
      end
   end

   // Priority pointer: follows the last accepted channel; shift rotates it when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         lowest_prio <= IDX_W'(INIT_LOWEST_PRIO);
      end else if (N > 1) begin
         if (accept) begin
            lowest_prio <= grant_idx;
         end else if (shift && !lock_hold) begin
            lowest_prio <= IDX_W'(rr_next(int'(lowest_prio), N));
         end
      end
   end

endmodule

// File: tb/tb_arbiter_rr_buffered.sv
// Self-checking bench for arbiter_rr_buffered (N=4, DWIDTH=16, INIT_LOWEST_PRIO=3).
// A behavioural model walks the priority order explicitly and is compared with the
// DUT every cycle; directed sequences pin the model with literal expectations, then
// randomized traffic with backpressure, shift and occasional reset follows.
// With ARB_RR_BURST_LOCK_EN defined the bench also drives in_last and checks out_last.
module tb_arbiter_rr_buffered;

   localparam int N      = 4;
   localparam int DWIDTH = 16;
   localparam int IDX_W  = 2;
   localparam int INIT   = N - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid [N-1:0];
   logic [DWIDTH-1:0] in_data  [N-1:0];
   logic              in_ready [N-1:0];
   logic              shift = 1'b0;
   logic              out_valid;
   logic [DWIDTH-1:0] out_data;
   logic [IDX_W-1:0]  out_index;
   logic              out_ready = 1'b1;
`ifdef ARB_RR_BURST_LOCK_EN
   logic              in_last [N-1:0];
   logic              out_last;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   arbiter_rr_buffered #(
      .DWIDTH           (DWIDTH),
      .N                (N),
      .INIT_LOWEST_PRIO (INIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .shift     (shift),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_index (out_index),
      .out_ready (out_ready)
`ifdef ARB_RR_BURST_LOCK_EN
      ,
      .in_last   (in_last),
      .out_last  (out_last)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_ready();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i] = in_ready[i];
      return v;
   endfunction

   function automatic bit last_of(input int c);
`ifdef ARB_RR_BURST_LOCK_EN
      return in_last[c];
`else
      return 1'b1;
`endif
   endfunction

   task automatic set_valid(input logic [N-1:0] p);
      for (int i = 0; i < N; i++) in_valid[i] = p[i];
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   bit              m_valid   = 1'b0;
   logic [DWIDTH-1:0] m_data  = '0;
   int              m_index   = 0;
   int              m_lp      = INIT;
   bit              m_locked  = 1'b0;
   int              m_lock_id = 0;
   bit              m_last    = 1'b0;

   initial begin : compare
      bit                n_valid, n_locked, n_last, load;
      logic [DWIDTH-1:0] n_data;
      int                n_index, n_lp, n_lock_id, w, c;
      logic [31:0]       exp_ready;
      forever begin
         @(negedge clk);
         load = !m_valid || out_ready;
         w    = -1;
         if (!rst) begin
            for (int k = 1; k <= N; k++) begin
               c = (m_lp + k) % N;
               if (w < 0 && in_valid[c] && (!m_locked || c == m_lock_id)) w = c;
            end
         end
         exp_ready = '0;
         if (load && w >= 0) exp_ready[w] = 1'b1;
         check("model_in_ready", pack_ready(), exp_ready);

         n_valid = m_valid; n_data = m_data; n_index = m_index; n_lp = m_lp;
         n_locked = m_locked; n_lock_id = m_lock_id; n_last = m_last;
         if (rst) begin
            n_valid = 1'b0; n_data = '0; n_index = 0; n_lp = INIT;
            n_locked = 1'b0; n_lock_id = 0; n_last = 1'b0;
         end else begin
            if (load && w >= 0) begin
               n_valid   = 1'b1;
               n_data    = in_data[w];
               n_index   = w;
               n_lp      = w;
               n_last    = last_of(w);
               n_locked  = !last_of(w);
               n_lock_id = w;
            end else begin
               if (load) n_valid = 1'b0;
               if (shift && !m_locked && N > 1) n_lp = (m_lp + 1) % N;
            end
         end

         @(posedge clk);
         #1;
         m_valid = n_valid; m_data = n_data; m_index = n_index; m_lp = n_lp;
         m_locked = n_locked; m_lock_id = n_lock_id; m_last = n_last;
         check("model_out_valid", out_valid, m_valid);
         check("model_out_data", out_data, m_data);
         check("model_out_index", out_index, m_index);
`ifdef ARB_RR_BURST_LOCK_EN
         if (m_valid) check("model_out_last", out_last, m_last);
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      for (int i = 0; i < N; i++) begin
         in_valid[i] = 1'b0;
         in_data[i]  = DWIDTH'(16'hA000 + i);
`ifdef ARB_RR_BURST_LOCK_EN
         in_last[i]  = 1'b1;
`endif
      end

      // Reset state.
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_index", out_index, 0);

      // 1: all valid, full throughput, order 0,1,2,3,0,...
      rst = 1'b0;
      set_valid(4'b1111);
      for (int k = 0; k < 8; k++) begin
         #1;
         check("rr_ready", pack_ready(), 32'd1 << (k % N));
         tick();
         check("rr_index", out_index, k % N);
         check("rr_data", out_data, 16'hA000 + (k % N));
      end

      // 2: ch1/ch3 valid, stall 3 cycles after the first beat.
      set_valid(4'b1010);
      #1; check("stall_first_ready", pack_ready(), 32'b0010);
      tick(); check("stall_first_index", out_index, 1);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1; check("stall_ready_zero", pack_ready(), 0);
         tick();
         check("stall_hold_valid", out_valid, 1);
         check("stall_hold_data", out_data, 16'hA001);
      end
      out_ready = 1'b1;
      #1; check("stall_release_ready", pack_ready(), 32'b1000);
      tick(); check("stall_release_index", out_index, 3);

      // 3: idle shifts 3->0->1, then ch0/ch2 valid -> ch2 wins.
      rst = 1'b1; tick(); rst = 1'b0;
      set_valid(4'b0000);
      shift = 1'b1; tick(); tick(); shift = 1'b0;
      set_valid(4'b0101);
      #1; check("shift_ready", pack_ready(), 32'b0100);
      tick(); check("shift_index", out_index, 2);

      // 4: accept of ch2 with shift in the same cycle -> pointer 2, so ch3 beats ch1.
      rst = 1'b1; tick(); rst = 1'b0;
      set_valid(4'b0100); shift = 1'b1;
      #1; check("acc_shift_ready", pack_ready(), 32'b0100);
      tick(); shift = 1'b0;
      set_valid(4'b1010);
      #1; check("acc_shift_next_ready", pack_ready(), 32'b1000);
      tick(); check("acc_shift_next_index", out_index, 3);

`ifdef ARB_RR_BURST_LOCK_EN
      // 5: ch0 three-beat burst with a gap, ch1 always valid.
      rst = 1'b1; tick(); rst = 1'b0;
      in_last[1] = 1'b1;
      set_valid(4'b0011); in_last[0] = 1'b0;
      #1; check("burst_b1_ready", pack_ready(), 32'b0001);
      tick(); check("burst_b1_last", out_last, 0);
      set_valid(4'b0010);
      #1; check("burst_gap_ready", pack_ready(), 0);
      tick(); check("burst_gap_valid", out_valid, 0);
      set_valid(4'b0011);
      #1; check("burst_b2_ready", pack_ready(), 32'b0001);
      tick(); check("burst_b2_last", out_last, 0);
      in_last[0] = 1'b1;
      #1; check("burst_b3_ready", pack_ready(), 32'b0001);
      tick(); check("burst_b3_last", out_last, 1);
      #1; check("burst_after_ready", pack_ready(), 32'b0010);
      tick(); check("burst_after_index", out_index, 1);
`endif

      // 6: reset while out_valid=1 drops the beat and restores the pointer.
      rst = 1'b1; tick(); rst = 1'b0;
      set_valid(4'b1111);
      tick(); tick();
      check("mid_rst_pre_valid", out_valid, 1);
      check("mid_rst_pre_index", out_index, 1);
      rst = 1'b1;
      #1; check("mid_rst_ready_zero", pack_ready(), 0);
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_index", out_index, 0);
      rst = 1'b0;
      #1; check("mid_rst_ptr_ready", pack_ready(), 32'b0001);
      tick();

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) begin
            in_valid[i] = ($urandom_range(0, 9) < 6);
            in_data[i]  = DWIDTH'($urandom);
`ifdef ARB_RR_BURST_LOCK_EN
            in_last[i]  = ($urandom_range(0, 9) < 5);
`endif
         end
         out_ready = ($urandom_range(0, 9) < 7);
         shift     = ($urandom_range(0, 9) < 2);
         rst       = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
